// File: rtl/tdp_be_ram_pkg.sv
// rtl/tdp_be_ram_pkg.sv - shared constants, state type and helpers for tdp_be_ram
package tdp_be_ram_pkg;

  localparam string WM_READ_FIRST  = "READ_FIRST";
  localparam string WM_WRITE_FIRST = "WRITE_FIRST";

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Address width for a given depth, never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/tdp_be_ram_opipe.sv
// rtl/tdp_be_ram_opipe.sv - per-port read data / valid register pipeline
module tdp_be_ram_opipe #(
  parameter int LATENCY = 1,
  parameter int WIDTH   = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [LATENCY-1:0] r_valid;
  logic [WIDTH-1:0]   r_data [LATENCY];

  // Data stages only load on valid so the output holds between accesses.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_valid <= '0;
      for (int i = 0; i < LATENCY; i++) r_data[i] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      if (i_valid) r_data[0] <= i_data;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
        if (r_valid[i-1]) r_data[i] <= r_data[i-1];
      end
    end
  end

  assign o_valid = r_valid[LATENCY-1];
  assign o_data  = r_data[LATENCY-1];

endmodule

// File: rtl/tdp_be_ram.sv
// rtl/tdp_be_ram.sv - true dual-port byte-enable RAM with collision arbitration and clear sweep
module tdp_be_ram
  import tdp_be_ram_pkg::*;
#(
  parameter int    RAM_WIDTH      = 32,
  parameter int    BYTE_WIDTH     = 8,
  parameter int    RAM_DEPTH      = 1024,
  parameter int    READ_LATENCY   = 1,
  parameter string WRITE_MODE     = "READ_FIRST",
  parameter int    CLEAR_ON_RESET = 1,
  localparam int   NB             = RAM_WIDTH / BYTE_WIDTH,
  localparam int   AW             = clog2(RAM_DEPTH)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 ena_in,
  input  logic [NB-1:0]        wea_in,
  input  logic [AW-1:0]        addra_in,
  input  logic [RAM_WIDTH-1:0] dina_in,
  output logic [RAM_WIDTH-1:0] douta_out,
  output logic                 valida_out,
  input  logic                 enb_in,
  input  logic [NB-1:0]        web_in,
  input  logic [AW-1:0]        addrb_in,
  input  logic [RAM_WIDTH-1:0] dinb_in,
  output logic [RAM_WIDTH-1:0] doutb_out,
  output logic                 validb_out,
  output logic                 busy_out,
  output logic                 collision_out
);

  localparam bit WF = (WRITE_MODE == WM_WRITE_FIRST);

  logic [RAM_WIDTH-1:0] r_mem [0:RAM_DEPTH-1];

  state_t               r_state, w_state_nxt;
  logic [AW-1:0]        r_clr_addr;
  logic                 r_coll;
  logic                 w_busy, w_acc_a, w_acc_b, w_inr_a, w_inr_b, w_same;
  logic [NB-1:0]        w_wr_a, w_wr_b;
  logic [RAM_WIDTH-1:0] w_old_a, w_old_b, w_new_a, w_new_b, w_rd_a, w_rd_b;

  generate
    if (RAM_DEPTH == (1 << AW)) begin : g_full
      assign w_inr_a = 1'b1;
      assign w_inr_b = 1'b1;
    end else begin : g_part
      assign w_inr_a = (int'(addra_in) < RAM_DEPTH);
      assign w_inr_b = (int'(addrb_in) < RAM_DEPTH);
    end
  endgenerate

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      r_clr_addr <= '0;
      r_coll     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_busy) r_clr_addr <= r_clr_addr + AW'(1);
      r_coll  <= w_same && (|(w_wr_a & w_wr_b));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      CLEAR: begin
        w_busy = 1'b1;
        if (r_clr_addr == AW'(RAM_DEPTH - 1)) w_state_nxt = RUN;
      end
      default: ;
    endcase
  end

  assign w_acc_a = ena_in && !w_busy;
  assign w_acc_b = enb_in && !w_busy;
  assign w_wr_a  = (w_acc_a && w_inr_a) ? wea_in : '0;
  assign w_wr_b  = (w_acc_b && w_inr_b) ? web_in : '0;
  assign w_same  = (addra_in == addrb_in);
  assign w_old_a = w_inr_a ? r_mem[addra_in] : '0;
  assign w_old_b = w_inr_b ? r_mem[addrb_in] : '0;

  // Post-write word as stored: port A owns overlapping lanes.
  always_comb begin
    w_new_a = w_old_a;
    w_new_b = w_old_b;
    for (int i = 0; i < NB; i++) begin
      if (w_same && w_wr_b[i]) w_new_a[i*BYTE_WIDTH +: BYTE_WIDTH] = dinb_in[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (w_wr_a[i])           w_new_a[i*BYTE_WIDTH +: BYTE_WIDTH] = dina_in[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (w_wr_b[i])           w_new_b[i*BYTE_WIDTH +: BYTE_WIDTH] = dinb_in[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (w_same && w_wr_a[i]) w_new_b[i*BYTE_WIDTH +: BYTE_WIDTH] = dina_in[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // A pure read never sees the other port's same-cycle write.
  assign w_rd_a = (WF && (|w_wr_a)) ? w_new_a : w_old_a;
  assign w_rd_b = (WF && (|w_wr_b)) ? w_new_b : w_old_b;

  always_ff @(posedge clk_in) begin
    if (w_busy) begin
      r_mem[r_clr_addr] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (w_wr_b[i]) r_mem[addrb_in][i*BYTE_WIDTH +: BYTE_WIDTH] <= dinb_in[i*BYTE_WIDTH +: BYTE_WIDTH];
        if (w_wr_a[i]) r_mem[addra_in][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina_in[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  tdp_be_ram_opipe #(.LATENCY(READ_LATENCY), .WIDTH(RAM_WIDTH)) u_opipe_a (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_valid (w_acc_a),
    .i_data  (w_rd_a),
    .o_valid (valida_out),
    .o_data  (douta_out)
  );

  tdp_be_ram_opipe #(.LATENCY(READ_LATENCY), .WIDTH(RAM_WIDTH)) u_opipe_b (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_valid (w_acc_b),
    .i_data  (w_rd_b),
    .o_valid (validb_out),
    .o_data  (doutb_out)
  );

  assign busy_out      = w_busy;
  assign collision_out = r_coll;

endmodule

// File: tb/tb_tdp_be_ram.sv
// tb/tb_tdp_be_ram.sv - directed vector bench for tdp_be_ram
module tb_tdp_be_ram;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        ena_in = 1'b0, enb_in = 1'b0;
  logic [3:0]  wea_in = '0, web_in = '0, addra_in = '0, addrb_in = '0;
  logic [31:0] dina_in = '0, dinb_in = '0;

  logic [31:0] da_rf, db_rf, da_wf, db_wf, da_l2, db_l2;
  logic        va_rf, vb_rf, va_wf, vb_wf, va_l2, vb_l2;
  logic        bz_rf, bz_wf, bz_l2, co_rf, co_wf, co_l2;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  tdp_be_ram #(.RAM_DEPTH(16), .READ_LATENCY(1), .WRITE_MODE("READ_FIRST"), .CLEAR_ON_RESET(1)) u_rf (
    .clk_in(clk_in), .rst_in(rst_in),
    .ena_in(ena_in), .wea_in(wea_in), .addra_in(addra_in), .dina_in(dina_in), .douta_out(da_rf), .valida_out(va_rf),
    .enb_in(enb_in), .web_in(web_in), .addrb_in(addrb_in), .dinb_in(dinb_in), .doutb_out(db_rf), .validb_out(vb_rf),
    .busy_out(bz_rf), .collision_out(co_rf));

  tdp_be_ram #(.RAM_DEPTH(12), .READ_LATENCY(1), .WRITE_MODE("WRITE_FIRST"), .CLEAR_ON_RESET(1)) u_wf (
    .clk_in(clk_in), .rst_in(rst_in),
    .ena_in(ena_in), .wea_in(wea_in), .addra_in(addra_in), .dina_in(dina_in), .douta_out(da_wf), .valida_out(va_wf),
    .enb_in(enb_in), .web_in(web_in), .addrb_in(addrb_in), .dinb_in(dinb_in), .doutb_out(db_wf), .validb_out(vb_wf),
    .busy_out(bz_wf), .collision_out(co_wf));

  tdp_be_ram #(.RAM_DEPTH(16), .READ_LATENCY(2), .WRITE_MODE("READ_FIRST"), .CLEAR_ON_RESET(1)) u_l2 (
    .clk_in(clk_in), .rst_in(rst_in),
    .ena_in(ena_in), .wea_in(wea_in), .addra_in(addra_in), .dina_in(dina_in), .douta_out(da_l2), .valida_out(va_l2),
    .enb_in(enb_in), .web_in(web_in), .addrb_in(addrb_in), .dinb_in(dinb_in), .doutb_out(db_l2), .validb_out(vb_l2),
    .busy_out(bz_l2), .collision_out(co_l2));

  typedef struct {
    logic        ena; logic [3:0] wea; logic [3:0] addra; logic [31:0] dina;
    logic        enb; logic [3:0] web; logic [3:0] addrb; logic [31:0] dinb;
    logic        va;  logic [31:0] da_rf; logic [31:0] da_wf;
    logic        vb;  logic [31:0] db_rf; logic [31:0] db_wf;
    logic        coll;
  } vec_t;

  vec_t vecs [16];
  logic [31:0] exp_mem [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    ena_in = 1'b0; enb_in = 1'b0; wea_in = '0; web_in = '0;
  endtask

  // Count cycles until each instance leaves the sweep; optionally hammer writes at addr 0 meanwhile.
  task automatic busy_count(input bit poke, output int f_rf, output int f_wf, output int f_l2, output int vhits);
    f_rf = 0; f_wf = 0; f_l2 = 0; vhits = 0;
    if (poke) begin
      ena_in = 1'b1; wea_in = 4'hF; addra_in = 4'd0; dina_in = 32'hFFFF_FFFF;
    end
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 8) idle();
      if (va_rf || va_wf || va_l2 || vb_rf || vb_wf || vb_l2) vhits++;
      if (!bz_rf && f_rf == 0) f_rf = k;
      if (!bz_wf && f_wf == 0) f_wf = k;
      if (!bz_l2 && f_l2 == 0) f_l2 = k;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f_rf, f_wf, f_l2, vh;

    //            ena  wea   addra  dina          enb  web   addrb  dinb          va   da_rf         da_wf         vb   db_rf         db_wf         coll
    vecs[0]  = '{1'b1, 4'hF, 4'd3,  32'hDEADBEEF, 1'b1, 4'h0, 4'd3,  32'h0,        1'b1, 32'h00000000, 32'hDEADBEEF, 1'b1, 32'h00000000, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 4'h2, 4'd3,  32'h00001200, 1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 32'hDEADBEEF, 32'hDEAD12EF, 1'b0, 32'h00000000, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b1, 4'h0, 4'd3,  32'h0,        1'b1, 4'h0, 4'd3,  32'h0,        1'b1, 32'hDEAD12EF, 32'hDEAD12EF, 1'b1, 32'hDEAD12EF, 32'hDEAD12EF, 1'b0};
    vecs[3]  = '{1'b1, 4'hF, 4'd5,  32'h11111111, 1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 32'h00000000, 32'h11111111, 1'b0, 32'hDEAD12EF, 32'hDEAD12EF, 1'b0};
    vecs[4]  = '{1'b1, 4'hF, 4'd5,  32'h22222222, 1'b1, 4'h0, 4'd5,  32'h0,        1'b1, 32'h11111111, 32'h22222222, 1'b1, 32'h11111111, 32'h11111111, 1'b0};
    vecs[5]  = '{1'b1, 4'hF, 4'd7,  32'hAAAAAAAA, 1'b1, 4'h3, 4'd7,  32'hBBBBBBBB, 1'b1, 32'h00000000, 32'hAAAAAAAA, 1'b1, 32'h00000000, 32'hAAAAAAAA, 1'b1};
    vecs[6]  = '{1'b1, 4'h0, 4'd7,  32'h0,        1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0, 32'h00000000, 32'hAAAAAAAA, 1'b0};
    vecs[7]  = '{1'b1, 4'hC, 4'd8,  32'hAAAAAAAA, 1'b1, 4'h3, 4'd8,  32'hBBBBBBBB, 1'b1, 32'h00000000, 32'hAAAABBBB, 1'b1, 32'h00000000, 32'hAAAABBBB, 1'b0};
    vecs[8]  = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 4'h0, 4'd8,  32'h0,        1'b0, 32'h00000000, 32'hAAAABBBB, 1'b1, 32'hAAAABBBB, 32'hAAAABBBB, 1'b0};
    vecs[9]  = '{1'b1, 4'hF, 4'd13, 32'h12345678, 1'b1, 4'h0, 4'd13, 32'h0,        1'b1, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 32'h00000000, 1'b0};
    vecs[10] = '{1'b1, 4'h0, 4'd13, 32'h0,        1'b1, 4'h0, 4'd13, 32'h0,        1'b1, 32'h12345678, 32'h00000000, 1'b1, 32'h12345678, 32'h00000000, 1'b0};
    vecs[11] = '{1'b1, 4'h0, 4'd5,  32'h0,        1'b1, 4'h0, 4'd1,  32'h0,        1'b1, 32'h22222222, 32'h22222222, 1'b1, 32'h00000000, 32'h00000000, 1'b0};
    vecs[12] = '{1'b1, 4'h0, 4'd3,  32'h0,        1'b1, 4'h8, 4'd3,  32'h55000000, 1'b1, 32'hDEAD12EF, 32'hDEAD12EF, 1'b1, 32'hDEAD12EF, 32'h55AD12EF, 1'b0};
    vecs[13] = '{1'b1, 4'h0, 4'd3,  32'h0,        1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 32'h55AD12EF, 32'h55AD12EF, 1'b0, 32'hDEAD12EF, 32'h55AD12EF, 1'b0};
    vecs[14] = '{1'b1, 4'h6, 4'd9,  32'h11111111, 1'b1, 4'h3, 4'd9,  32'h22222222, 1'b1, 32'h00000000, 32'h00111122, 1'b1, 32'h00000000, 32'h00111122, 1'b1};
    vecs[15] = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 4'h0, 4'd9,  32'h0,        1'b0, 32'h00000000, 32'h00111122, 1'b1, 32'h00111122, 32'h00111122, 1'b0};

    exp_mem = '{32'h0, 32'h0, 32'h0, 32'h55AD12EF, 32'h0, 32'h22222222, 32'h0, 32'hAAAAAAAA};

    // Reset values
    step(); step(); step();
    chk("rst_da", da_rf, 32'h0);
    chk("rst_va", 32'(va_rf), 32'h0);
    chk("rst_vb", 32'(vb_rf), 32'h0);
    chk("rst_coll", 32'(co_rf), 32'h0);
    chk("rst_busy", 32'(bz_rf), 32'h1);

    // Sweep length; accesses during the sweep must be ignored
    rst_in = 1'b0;
    busy_count(1'b1, f_rf, f_wf, f_l2, vh);
    chk("busy_len_rf", 32'(f_rf), 32'd16);
    chk("busy_len_wf", 32'(f_wf), 32'd12);
    chk("busy_len_l2", 32'(f_l2), 32'd16);
    chk("valid_in_sweep", 32'(vh), 32'd0);

    // Every word cleared, valid one cycle after each read
    for (int i = 0; i < 16; i++) begin
      enb_in = 1'b1; addrb_in = 4'(i);
      step();
      chk($sformatf("clr_vb[%0d]", i), 32'(vb_rf), 32'h1);
      chk($sformatf("clr_db[%0d]", i), db_rf, 32'h0);
    end
    idle();
    step();
    chk("clr_vb_drop", 32'(vb_rf), 32'h0);

    for (int i = 0; i < 16; i++) begin
      ena_in = vecs[i].ena; wea_in = vecs[i].wea; addra_in = vecs[i].addra; dina_in = vecs[i].dina;
      enb_in = vecs[i].enb; web_in = vecs[i].web; addrb_in = vecs[i].addrb; dinb_in = vecs[i].dinb;
      step();
      chk($sformatf("v%0d.va_rf", i), 32'(va_rf), 32'(vecs[i].va));
      chk($sformatf("v%0d.va_wf", i), 32'(va_wf), 32'(vecs[i].va));
      chk($sformatf("v%0d.da_rf", i), da_rf, vecs[i].da_rf);
      chk($sformatf("v%0d.da_wf", i), da_wf, vecs[i].da_wf);
      chk($sformatf("v%0d.vb_rf", i), 32'(vb_rf), 32'(vecs[i].vb));
      chk($sformatf("v%0d.vb_wf", i), 32'(vb_wf), 32'(vecs[i].vb));
      chk($sformatf("v%0d.db_rf", i), db_rf, vecs[i].db_rf);
      chk($sformatf("v%0d.db_wf", i), db_wf, vecs[i].db_wf);
      chk($sformatf("v%0d.coll_rf", i), 32'(co_rf), 32'(vecs[i].coll));
      chk($sformatf("v%0d.coll_wf", i), 32'(co_wf), 32'(vecs[i].coll));
    end
    idle();
    step(); step();

    // Streaming B reads 0..7: latency 1 vs latency 2
    for (int k = 0; k < 12; k++) begin
      enb_in = (k < 8); addrb_in = 4'(k % 8);
      step();
      if (k < 8) begin
        chk($sformatf("s%0d.vb_rf", k), 32'(vb_rf), 32'h1);
        chk($sformatf("s%0d.db_rf", k), db_rf, exp_mem[k]);
      end else begin
        chk($sformatf("s%0d.vb_rf", k), 32'(vb_rf), 32'h0);
      end
      if (k >= 1 && k <= 8) begin
        chk($sformatf("s%0d.vb_l2", k), 32'(vb_l2), 32'h1);
        chk($sformatf("s%0d.db_l2", k), db_l2, exp_mem[k-1]);
      end else begin
        chk($sformatf("s%0d.vb_l2", k), 32'(vb_l2), 32'h0);
      end
    end
    idle();

    // Asynchronous reset clears outputs immediately, then reset again mid-sweep
    rst_in = 1'b1;
    #1;
    chk("arst_db_rf", db_rf, 32'h0);
    chk("arst_db_l2", db_l2, 32'h0);
    chk("arst_busy", 32'(bz_rf), 32'h1);
    step(); step();
    rst_in = 1'b0;
    for (int k = 0; k < 9; k++) step();
    chk("mid_busy", 32'(bz_rf), 32'h1);
    rst_in = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bz_rf), 32'h1);
    step();
    rst_in = 1'b0;
    busy_count(1'b0, f_rf, f_wf, f_l2, vh);
    chk("rebusy_len_rf", 32'(f_rf), 32'd16);
    chk("rebusy_len_wf", 32'(f_wf), 32'd12);

    enb_in = 1'b1; addrb_in = 4'd3;
    step();
    idle();
    chk("reclr_vb_rf", 32'(vb_rf), 32'h1);
    chk("reclr_db_rf", db_rf, 32'h0);
    step();
    chk("reclr_vb_l2", 32'(vb_l2), 32'h1);
    chk("reclr_db_l2", db_l2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
